// File: rtl/ahb_wr_drain.sv
// ahb_wr_drain
// Consumer end of the posted-write buffer. Pops one {addr, data} entry at a
// time and issues it on AHB-Lite as a single NONSEQ word write, then waits
// for the data phase to finish before popping the next entry.
//
// Optional error log: define AHB_WR_DRAIN_ERR_LOG_EN to record the first
// errored write in err_flag/err_addr. When it is undefined both outputs are
// tied to 0 and err_clr is ignored.
//
// Ports
//   clk, rstn          clock, asynchronous active-low reset
//   drain_en           level, permits new pops (in-flight entry always finishes)
//   fifo_empty         write-buffer empty flag
//   fifo_rd_en         pop request; fifo_data is valid the following cycle
//   fifo_data          {addr, data} entry, addr in the upper field
//   HADDR..HPROT       AHB-Lite initiator address/control and write data
//   HREADY, HRESP      AHB-Lite transfer ready and response (1 = ERROR)
//   busy               high whenever the FSM is not IDLE
//   wr_done            one-cycle pulse after each completed write (OKAY or ERROR)
//   err_flag/err_addr  sticky first-error record
//   err_clr            clears the error record
//
// Handshake: a pop happens on a clock edge where fifo_rd_en is high; the
// entry is sampled one cycle later. On the bus, a phase (address or data)
// completes on a clock edge where HREADY is high; until then every output
// of that phase is held stable.
module ahb_wr_drain #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           drain_en,
  input  logic                           fifo_empty,
  output logic                           fifo_rd_en,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] fifo_data,
  output logic [ADDR_WIDTH-1:0]          HADDR,
  output logic [1:0]                     HTRANS,
  output logic                           HWRITE,
  output logic [2:0]                     HSIZE,
  output logic [2:0]                     HBURST,
  output logic [3:0]                     HPROT,
  output logic [DATA_WIDTH-1:0]          HWDATA,
  input  logic                           HREADY,
  input  logic                           HRESP,
  output logic                           busy,
  output logic                           wr_done,
  output logic                           err_flag,
  output logic [ADDR_WIDTH-1:0]          err_addr,
  input  logic                           err_clr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ADDR = 2'd2,
    S_DATA = 2'd3
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_addr_q;
  logic [DATA_WIDTH-1:0]   r_data_q;
  logic [1:0]              r_htrans;
  logic                    r_hwrite;
  logic                    r_busy;
  logic                    r_wr_done;

  logic                    w_pop;
  logic                    w_cmpl;

  // Pop only from IDLE. rstn gates it so no pop is requested while reset
  // is held, even though the state is already IDLE.
  assign w_pop      = rstn & (r_state == S_IDLE) & drain_en & ~fifo_empty;
  assign fifo_rd_en = w_pop;

  // Data-phase completion edge: the write is done, OKAY or ERROR.
  assign w_cmpl = (r_state == S_DATA) & HREADY;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_addr_q  <= '0;
      r_data_q  <= '0;
      r_htrans  <= HTRANS_IDLE;
      r_hwrite  <= 1'b0;
      r_busy    <= 1'b0;
      r_wr_done <= 1'b0;
    end else begin
      r_wr_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_state <= S_LOAD;
            r_busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          // Entry is on fifo_data this cycle; address phase starts next.
          r_addr_q <= fifo_data[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
          r_data_q <= fifo_data[DATA_WIDTH-1:0];
          r_htrans <= HTRANS_NONSEQ;
          r_hwrite <= 1'b1;
          r_state  <= S_ADDR;
        end
        S_ADDR: begin
          if (HREADY) begin
            // HTRANS drops to IDLE for the data phase, so an ERROR response
            // needs no cancel of a following transfer.
            r_htrans <= HTRANS_IDLE;
            r_hwrite <= 1'b0;
            r_state  <= S_DATA;
          end
        end
        S_DATA: begin
          if (HREADY) begin
            r_wr_done <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign HADDR   = r_addr_q;
  assign HWDATA  = r_data_q;
  assign HTRANS  = r_htrans;
  assign HWRITE  = r_hwrite;
  assign HSIZE   = 3'b010;
  assign HBURST  = 3'b000;
  assign HPROT   = 4'b0011;
  assign busy    = r_busy;
  assign wr_done = r_wr_done;

`ifdef AHB_WR_DRAIN_ERR_LOG_EN
  logic                  r_err_flag;
  logic [ADDR_WIDTH-1:0] r_err_addr;
  logic                  w_err_cmpl;

  assign w_err_cmpl = w_cmpl & HRESP;

  // Keeps the first error only. A clear arriving with a new error is
  // overridden by that error, so it is never lost.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_err_flag <= 1'b0;
      r_err_addr <= '0;
    end else if (w_err_cmpl && (!r_err_flag || err_clr)) begin
      r_err_flag <= 1'b1;
      r_err_addr <= r_addr_q;
    end else if (err_clr) begin
      r_err_flag <= 1'b0;
      r_err_addr <= '0;
    end
  end

  assign err_flag = r_err_flag;
  assign err_addr = r_err_addr;
`else
  logic w_unused;
  assign w_unused = ^{err_clr, HRESP, w_cmpl};
  assign err_flag = 1'b0;
  assign err_addr = '0;
`endif

endmodule

// File: tb/tb_ahb_wr_drain.sv
// Testbench for ahb_wr_drain: FIFO and AHB slave models, per-cycle
// scoreboard of bus/handshake outputs, table of single-entry writes with
// varying wait states and error responses, plus sequences for back-to-back
// draining, drain_en drop and reset in the data phase.
module tb_ahb_wr_drain;

`ifdef AHB_WR_DRAIN_ERR_LOG_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk;
  logic        rstn;
  logic        drain_en;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [63:0] fifo_data;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HRESP;
  logic        busy;
  logic        wr_done;
  logic        err_flag;
  logic [31:0] err_addr;
  logic        err_clr;

  ahb_wr_drain #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rstn(rstn), .drain_en(drain_en), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_data(fifo_data), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP),
    .busy(busy), .wr_done(wr_done), .err_flag(err_flag), .err_addr(err_addr),
    .err_clr(err_clr)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- models and scoreboard ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          aw;   // HREADY-low cycles in the address phase
    int          dw;   // HREADY-low cycles in the data phase
    bit          err;  // ERROR response in the data phase
  } ent_t;

  typedef struct {
    ent_t        e;
    int          exp_lat;  // cycles from pop to wr_done
    bit          exp_ef;
    logic [31:0] exp_ea;
  } vec_t;

  ent_t        fifo_q[$];
  logic [63:0] exp_q[$];
  int          done_cyc_q[$];

  int          checks = 0;
  int          errors = 0;
  int          ph = 0;          // 0 idle, 1 load, 2 addr phase, 3 data phase
  int          aw_left, dw_left;
  bit          cur_err;
  bit          exp_done_next = 1'b0;
  bit          m_ef = 1'b0;
  logic [31:0] m_ea = '0;
  int          cyc_n = 0;
  int          last_pop = 0;
  int          last_done = 0;
  int          n_done = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_ent(input ent_t e);
    fifo_q.push_back(e);
    fifo_empty = 1'b0;
  endtask

  // One clock cycle, entered and left at posedge+1.
  task automatic cyc();
    bit cmpl_err;
    HREADY = 1'b1;
    HRESP  = 1'b0;
    if (ph == 2 && aw_left > 0) HREADY = 1'b0;
    if (ph == 3) begin
      HRESP = cur_err;
      if (dw_left > 0) HREADY = 1'b0;
    end
    #1;
    chk("busy", busy, ph != 0);
    chk("fifo_rd_en", fifo_rd_en, (ph == 0) && drain_en && (fifo_q.size() != 0));
    chk("htrans", HTRANS, (ph == 2) ? 2'b10 : 2'b00);
    chk("hwrite", HWRITE, ph == 2);
    if (ph >= 2) chk("haddr", HADDR, exp_q[0][63:32]);
    if (ph == 3) chk("hwdata", HWDATA, exp_q[0][31:0]);
    chk("wr_done", wr_done, exp_done_next);
    chk("err_flag", err_flag, m_ef);
    chk("err_addr", err_addr, m_ea);
    if (wr_done) begin
      last_done = cyc_n;
      n_done++;
      done_cyc_q.push_back(cyc_n);
    end
    @(posedge clk);
    #1;
    exp_done_next = 1'b0;
    cmpl_err = 1'b0;
    if (ph == 3 && dw_left == 0) begin
      cmpl_err = cur_err;
      if (ERR_EN && cmpl_err && (!m_ef || err_clr)) begin
        m_ef = 1'b1;
        m_ea = exp_q[0][63:32];
      end else if (ERR_EN && err_clr) begin
        m_ef = 1'b0;
        m_ea = '0;
      end
      exp_done_next = 1'b1;
      void'(exp_q.pop_front());
      ph = 0;
    end else begin
      if (ERR_EN && err_clr) begin
        m_ef = 1'b0;
        m_ea = '0;
      end
      if (ph == 3) dw_left--;
      else if (ph == 2) begin
        if (aw_left > 0) aw_left--;
        else ph = 3;
      end else if (ph == 1) ph = 2;
      else if (drain_en && fifo_q.size() != 0) begin
        ent_t e;
        e = fifo_q.pop_front();
        fifo_data = {e.addr, e.data};
        exp_q.push_back({e.addr, e.data});
        aw_left  = e.aw;
        dw_left  = e.dw;
        cur_err  = e.err;
        last_pop = cyc_n;
        ph = 1;
      end
    end
    cyc_n++;
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic run_until_done(input int n_target, input int budget);
    int start;
    int k;
    start = n_done;
    k = 0;
    while ((n_done - start) < n_target && k < budget) begin
      cyc();
      k++;
    end
    if ((n_done - start) < n_target) chk("done_timeout", n_done - start, n_target);
  endtask

  task automatic run_until_ph(input int target, input int budget);
    int k;
    k = 0;
    while (ph != target && k < budget) begin
      cyc();
      k++;
    end
    if (ph != target) chk("phase_timeout", ph, target);
  endtask

  // ---------------- test ----------------
  vec_t vecs[6];

  initial begin
    ent_t e;
    logic [31:0] ea2000;
    ea2000 = ERR_EN ? 32'h2000 : 32'h0;
    vecs[0] = '{e: '{32'h0000_1000, 32'hDEAD_BEEF, 0, 0, 1'b0}, exp_lat: 4, exp_ef: 1'b0,   exp_ea: 32'h0};
    vecs[1] = '{e: '{32'h0000_2000, 32'h1111_2222, 0, 1, 1'b1}, exp_lat: 5, exp_ef: ERR_EN, exp_ea: ea2000};
    vecs[2] = '{e: '{32'h0000_3004, 32'h3333_4444, 2, 0, 1'b0}, exp_lat: 6, exp_ef: ERR_EN, exp_ea: ea2000};
    vecs[3] = '{e: '{32'h0000_4000, 32'h5555_6666, 0, 3, 1'b0}, exp_lat: 7, exp_ef: ERR_EN, exp_ea: ea2000};
    vecs[4] = '{e: '{32'h0000_5000, 32'h7777_8888, 1, 1, 1'b1}, exp_lat: 6, exp_ef: ERR_EN, exp_ea: ea2000};
    vecs[5] = '{e: '{32'hFFFF_FFFC, 32'hFFFF_FFFF, 0, 0, 1'b0}, exp_lat: 4, exp_ef: ERR_EN, exp_ea: ea2000};

    rstn = 1'b0; drain_en = 1'b1; fifo_empty = 1'b1; HREADY = 1'b1; HRESP = 1'b0;
    err_clr = 1'b0; fifo_data = 64'hA5A5_A5A5_5A5A_5A5A;
    #12;
    chk("rst_htrans", HTRANS, 2'b00);
    chk("rst_hwrite", HWRITE, 1'b0);
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wr_done", wr_done, 1'b0);
    chk("rst_rd_en", fifo_rd_en, 1'b0);
    chk("rst_err_flag", err_flag, 1'b0);
    chk("rst_err_addr", err_addr, 32'h0);
    chk("hsize", HSIZE, 3'b010);
    chk("hburst", HBURST, 3'b000);
    chk("hprot", HPROT, 4'b0011);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Empty FIFO with drain enabled: no pops, bus stays idle.
    repeat (3) cyc();

    // Table of single writes.
    for (int i = 0; i < 6; i++) begin
      push_ent(vecs[i].e);
      run_until_done(1, 40);
      chk($sformatf("latency[%0d]", i), last_done - last_pop, vecs[i].exp_lat);
      chk($sformatf("tab_err_flag[%0d]", i), err_flag, vecs[i].exp_ef);
      chk($sformatf("tab_err_addr[%0d]", i), err_addr, vecs[i].exp_ea);
    end

    // err_clr clears the record (no-op when logging is compiled out).
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("clr_err_flag", err_flag, 1'b0);
    chk("clr_err_addr", err_addr, 32'h0);

    // Three entries back to back: completions exactly 4 cycles apart.
    done_cyc_q.delete();
    for (int i = 0; i < 3; i++) begin
      e = '{32'h0000_8000 + 32'(i * 4), $urandom, 0, 0, 1'b0};
      push_ent(e);
    end
    run_until_done(3, 60);
    if (done_cyc_q.size() == 3) begin
      chk("spacing0", done_cyc_q[1] - done_cyc_q[0], 4);
      chk("spacing1", done_cyc_q[2] - done_cyc_q[1], 4);
    end else begin
      chk("spacing_count", done_cyc_q.size(), 3);
    end

    // drain_en dropped in the address phase: current write finishes only.
    e = '{32'h0000_9000, 32'hCAFE_0001, 1, 0, 1'b0};
    push_ent(e);
    e = '{32'h0000_9004, 32'hCAFE_0002, 0, 0, 1'b0};
    push_ent(e);
    run_until_ph(2, 10);
    drain_en = 1'b0;
    run_until_done(1, 20);
    repeat (6) cyc();
    chk("no_pop_while_disabled", fifo_q.size(), 1);
    drain_en = 1'b1;
    run_until_done(1, 20);

    // Reset asserted in the data phase.
    e = '{32'h0000_A000, 32'h0BAD_F00D, 0, 3, 1'b0};
    push_ent(e);
    e = '{32'h0000_A004, 32'h600D_F00D, 0, 0, 1'b0};
    push_ent(e);
    run_until_ph(3, 10);
    rstn = 1'b0;
    #1;
    chk("rst_mid_htrans", HTRANS, 2'b00);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_rd_en", fifo_rd_en, 1'b0);
    chk("rst_mid_hwrite", HWRITE, 1'b0);
    @(posedge clk); #1;
    chk("rst_hold_rd_en", fifo_rd_en, 1'b0);
    chk("rst_hold_fifo", fifo_q.size(), 1);
    rstn = 1'b1;
    ph = 0;
    exp_q.delete();
    exp_done_next = 1'b0;
    m_ef = 1'b0;
    m_ea = '0;
    run_until_done(1, 20);
    chk("rst_resume_drained", fifo_q.size(), 0);
    repeat (2) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
